// File: rtl/fp_as_issue_queue.sv
// Operand issue queue in front of the single-precision add/sub datapath.
// Buffers {a, b, sub} pairs in a first-word-fall-through FIFO. Each pair is
// classified as it is accepted, and the flags are stored with the entry.
// Each accepted pair also gets a sequence tag.
module fp_as_issue_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_a,
   output logic [31:0]      out_b,
   output logic             out_sub,
   output logic             out_eff_sub,
   output logic             out_exc,
   output logic             out_zero_a,
   output logic             out_zero_b,
   output logic [TAG_W-1:0] out_tag,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic             sub;
      logic             eff_sub;
      logic             exc;
      logic             zero_a;
      logic             zero_b;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           new_entry;
   entry_t           head;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [TAG_W-1:0] tag_cnt;
   logic             blank;
   logic             push;
   logic             pop;

   // Ready and valid depend only on the registered occupancy.
   // This keeps in_valid away from out_valid and out_ready away from in_ready.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Classify the incoming pair now; the flags are never recomputed later.
   always_comb begin
      new_entry         = '0;
      new_entry.a       = in_a;
      new_entry.b       = in_b;
      new_entry.sub     = in_sub;
      new_entry.eff_sub = in_sub ^ in_a[31] ^ in_b[31];
      new_entry.exc     = (in_a[30:23] == 8'hFF) | (in_b[30:23] == 8'hFF);
      new_entry.zero_a  = (in_a[30:0] == 31'd0);
      new_entry.zero_b  = (in_b[30:0] == 31'd0);
      new_entry.tag     = tag_cnt;
   end

   // Storage write. The array itself is never reset.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push)
         mem[wr_ptr] <= new_entry;
   end

   // Pointers, occupancy, tag counter and the post-reset blanking flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         tag_cnt <= '0;
         blank   <= 1'b1;
      end else begin
         // A push in the flush cycle drops the entry but still uses up its tag.
         if (push)
            tag_cnt <= tag_cnt + TAG_W'(1);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
               blank  <= 1'b0;
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
               count <= count + (AW+1)'(1);
            else if (pop && !push)
               count <= count - (AW+1)'(1);
         end
      end
   end

   // Until the first entry is stored, present zeros instead of uninitialised storage.
   always_comb begin
      head = mem[rd_ptr];
      if (blank)
         head = '0;
   end

   assign out_a       = head.a;
   assign out_b       = head.b;
   assign out_sub     = head.sub;
   assign out_eff_sub = head.eff_sub;
   assign out_exc     = head.exc;
   assign out_zero_a  = head.zero_a;
   assign out_zero_b  = head.zero_b;
   assign out_tag     = head.tag;

endmodule

// File: tb/tb_fp_as_issue_queue.sv
// Randomised and directed bench for fp_as_issue_queue.
// A queue-based reference model follows every handshake.
module tb_fp_as_issue_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_a = '0;
   logic [31:0]      in_b = '0;
   logic             in_sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_a;
   logic [31:0]      out_b;
   logic             out_sub;
   logic             out_eff_sub;
   logic             out_exc;
   logic             out_zero_a;
   logic             out_zero_b;
   logic [TAG_W-1:0] out_tag;
   logic [AW:0]      count;

   fp_as_issue_queue #(.DEPTH(DEPTH), .AW(AW), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_sub(out_sub),
      .out_eff_sub(out_eff_sub), .out_exc(out_exc),
      .out_zero_a(out_zero_a), .out_zero_b(out_zero_b),
      .out_tag(out_tag), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      a;
      logic [31:0]      b;
      logic             sub;
      logic [TAG_W-1:0] tag;
   } pair_t;

   pair_t            q[$];
   logic [TAG_W-1:0] m_tag;
   bit               m_blank;
   int               n_vec = 0;
   int               n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Compare every output against the model's view of the queue.
   task automatic check_outputs();
      pair_t h;
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         h = q[0];
         chk("out_a", 64'(out_a), 64'(h.a));
         chk("out_b", 64'(out_b), 64'(h.b));
         chk("out_sub", 64'(out_sub), 64'(h.sub));
         chk("eff_sub", 64'(out_eff_sub), 64'(h.sub ^ h.a[31] ^ h.b[31]));
         chk("exc", 64'(out_exc), 64'((h.a[30:23] == 8'hFF) || (h.b[30:23] == 8'hFF)));
         chk("zero_a", 64'(out_zero_a), 64'(h.a[30:0] == 0));
         chk("zero_b", 64'(out_zero_b), 64'(h.b[30:0] == 0));
         chk("out_tag", 64'(out_tag), 64'(h.tag));
      end else if (m_blank) begin
         chk("rst_out_a", 64'(out_a), 64'd0);
         chk("rst_out_b", 64'(out_b), 64'd0);
         chk("rst_out_tag", 64'(out_tag), 64'd0);
      end
   endtask

   // Advance the model on a clock edge using the current input values.
   task automatic model_update();
      bit do_push, do_pop;
      pair_t p;
      if (rst) begin
         q.delete();
         m_tag   = '0;
         m_blank = 1'b1;
         return;
      end
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (flush) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            p.a = in_a; p.b = in_b; p.sub = in_sub; p.tag = m_tag;
            q.push_back(p);
            m_blank = 1'b0;
         end
      end
      if (do_push) m_tag = m_tag + 1'b1;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 5))
         0: v[30:0] = '0;
         1: v[30:23] = 8'hFF;
         default: ;
      endcase
      return v;
   endfunction

   task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic s);
      in_valid = 1'b1; in_a = a; in_b = b; in_sub = s;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      // Power-up reset, checked right after the edge.
      @(posedge clk); #1;
      @(posedge clk); model_update(); #1;
      rst = 1'b0;

      // Single pair passes straight through.
      out_ready = 1'b1;
      offer(32'h4383C7AE, 32'h4164F5C3, 1'b0);
      cycle();
      in_valid = 1'b0;
      repeat (2) cycle();

      // Fill to DEPTH, hold a fifth offer, then drain.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offer(rand_fp(), rand_fp(), 1'($urandom));
         cycle();
      end
      offer(32'h40490FDB, 32'hC0490FDB, 1'b1);
      repeat (3) cycle();
      out_ready = 1'b1;
      repeat (DEPTH + 1) cycle();
      in_valid = 1'b0;
      repeat (2) cycle();

      // Classification corner pairs.
      offer(32'h7F800000, 32'h3F800000, 1'b0); cycle();
      offer(32'h80000000, 32'h00000000, 1'b0); cycle();
      offer(32'hBF3AE148, 32'h3EB33333, 1'b1); cycle();
      in_valid = 1'b0; cycle();

      // Steady push and pop at occupancy 1; the tag counter wraps.
      out_ready = 1'b0;
      offer(rand_fp(), rand_fp(), 1'b0); cycle();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         offer(rand_fp(), rand_fp(), 1'($urandom));
         cycle();
      end
      in_valid = 1'b0; cycle(); cycle();

      // Flush at occupancy 3 together with a push and a pop.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(rand_fp(), rand_fp(), 1'b0); cycle();
      end
      out_ready = 1'b1; flush = 1'b1;
      offer(rand_fp(), rand_fp(), 1'b0); cycle();
      flush = 1'b0; in_valid = 1'b0; cycle();
      offer(rand_fp(), rand_fp(), 1'b1); cycle();
      in_valid = 1'b0; cycle();

      // Reset mid-stream at occupancy 2.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         offer(rand_fp(), rand_fp(), 1'b0); cycle();
      end
      do_reset();
      offer(rand_fp(), rand_fp(), 1'b0); cycle();
      in_valid = 1'b0; cycle();

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_a      = rand_fp();
         in_b      = rand_fp();
         in_sub    = 1'($urandom);
         flush     = ($urandom_range(0, 24) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
